// File: rtl/ssd_scan_mux.sv
// Multiplexed scanner for a common-anode seven-segment display with frame-aligned commits.
// Optional leading-zero blanking when SSD_LEADING_ZERO_BLANK_EN is defined.
module ssd_scan_mux #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  value_valid,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic [DIGITS-1:0]     dp_in,
   output logic [3:0]            digit_bin,
   output logic [DIGITS-1:0]     an,
   output logic                  dp_n,
   output logic                  frame_tick
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] ILAST = IW'(DIGITS - 1);

   logic [PW-1:0]          pcnt_q, pcnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0]    shadow_val_q, shadow_val_d;
   logic [DIGITS-1:0]      shadow_dp_q, shadow_dp_d;
   logic                   pending_q, pending_d;
   logic [4*DIGITS-1:0]    disp_val_q, disp_val_d;
   logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
   logic [3:0]             digit_bin_q, digit_bin_d;
   logic [DIGITS-1:0]      an_q, an_d;
   logic                   dp_n_q, dp_n_d;
   logic                   ftick_q, ftick_d;

   logic                   slot_end;
   logic                   boundary;
   logic [DIGITS-1:0]      blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q       <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         digit_bin_q  <= '0;
         an_q         <= '1;
         dp_n_q       <= 1'b1;
         ftick_q      <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         digit_bin_q  <= digit_bin_d;
         an_q         <= an_d;
         dp_n_q       <= dp_n_d;
         ftick_q      <= ftick_d;
      end
   end

   assign slot_end = (pcnt_q == PLAST);
   assign boundary = slot_end && (idx_q == ILAST);

   always_comb begin
      pcnt_d = slot_end ? '0 : pcnt_q + PW'(1);
      idx_d  = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == ILAST) ? '0 : idx_q + IW'(1);
      end
   end

   // A strobe on the boundary cycle goes straight to the display, skipping the shadow.
   always_comb begin
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      pending_d    = pending_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      ftick_d      = boundary;
      if (boundary) begin
         pending_d = 1'b0;
         if (value_valid) begin
            disp_val_d = value_in;
            disp_dp_d  = dp_in;
         end else if (pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
         end
      end else if (value_valid) begin
         shadow_val_d = value_in;
         shadow_dp_d  = dp_in;
         pending_d    = 1'b1;
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   always_comb begin
      blank = '0;
      for (int k = 1; k < DIGITS; k++) begin
         blank[k] = ((disp_val_q >> (4 * k)) == '0);
      end
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      logic [DIGITS-1:0] onehot;
      logic              dpsel;
      logic              blk;
      onehot      = '0;
      dpsel       = 1'b0;
      blk         = 1'b0;
      digit_bin_d = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            digit_bin_d = disp_val_q[4*k +: 4];
            onehot[k]   = 1'b1;
            dpsel       = disp_dp_q[k];
            blk         = blank[k];
         end
      end
      an_d   = blk ? '1 : ~onehot;
      dp_n_d = blk | ~dpsel;
   end

   assign digit_bin  = digit_bin_q;
   assign an         = an_q;
   assign dp_n       = dp_n_q;
   assign frame_tick = ftick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Directed bench for ssd_scan_mux with a per-frame expected-value scoreboard.
// Expected display contents are queued as values are strobed and popped per frame.
module tb_ssd_scan_mux;

   localparam int DIGITS = 4;
   localparam int RDIV   = 4;

   logic        clk;
   logic        rst_n;
   logic        value_valid;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  digit_bin;
   logic [3:0]  an;
   logic        dp_n;
   logic        frame_tick;

   int n_chk;
   int n_fail;

   typedef struct packed {
      logic [15:0] val;
      logic [3:0]  dp;
   } frame_t;

   frame_t exp_q[$];

   ssd_scan_mux #(
      .DIGITS(DIGITS),
      .REFRESH_DIV(RDIV)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .value_valid(value_valid),
      .value_in(value_in),
      .dp_in(dp_in),
      .digit_bin(digit_bin),
      .an(an),
      .dp_n(dp_n),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit blanked(input logic [15:0] v, input int d);
`ifdef SSD_LEADING_ZERO_BLANK_EN
      return (d > 0) && ((v >> (4 * d)) == 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   // One full frame, starting right after a frame_tick (or reset release).
   task automatic run_frame(input int s1, input logic [15:0] v1,
                            input logic [3:0] p1, input int s2,
                            input logic [15:0] v2, input logic [3:0] p2);
      frame_t e;
      frame_t nxt;
      int d;
      logic [3:0] ea;
      logic [3:0] oh;
      logic ed;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL scoreboard: observed empty expected entry");
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      nxt = e;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         d  = i / RDIV;
         oh = 4'b0001 << d;
         ea = blanked(e.val, d) ? 4'hF : ~oh;
         ed = blanked(e.val, d) ? 1'b1 : ~e.dp[d];
         chk("an", {12'h0, an}, {12'h0, ea});
         chk("digit_bin", {12'h0, digit_bin}, {12'h0, e.val[4*d +: 4]});
         chk("dp_n", {15'h0, dp_n}, {15'h0, ed});
         chk("frame_tick", {15'h0, frame_tick}, {15'h0, (i == 15)});
         if (i == s1) begin
            value_valid = 1'b1;
            value_in    = v1;
            dp_in       = p1;
            nxt         = '{val: v1, dp: p1};
         end else if (i == s2) begin
            value_valid = 1'b1;
            value_in    = v2;
            dp_in       = p2;
            nxt         = '{val: v2, dp: p2};
         end else begin
            value_valid = 1'b0;
         end
      end
      value_valid = 1'b0;
      exp_q.push_back(nxt);
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      value_valid = 1'b0;
      value_in    = 16'h0;
      dp_in       = 4'h0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("an_rst", {12'h0, an}, 16'h000F);
      end
      chk("digit_bin_rst", {12'h0, digit_bin}, 16'h0);
      chk("dp_n_rst", {15'h0, dp_n}, 16'h1);
      chk("frame_tick_rst", {15'h0, frame_tick}, 16'h0);
      rst_n = 1'b1;
      exp_q.push_back('{val: 16'h0, dp: 4'h0});

      // Idle frame after reset, then mid-frame strobe of 1A2F.
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame(5, 16'h1A2F, 4'b0100, -1, 16'h0, 4'h0);
      // Last write wins.
      run_frame(3, 16'h1111, 4'h0, 9, 16'h2222, 4'h0);
      // Shadow holds 5555, boundary strobe of 0BEE wins.
      run_frame(4, 16'h5555, 4'h0, 14, 16'h0BEE, 4'h0);
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      // 0BEE must persist: pending is clear.
      run_frame(2, 16'h0007, 4'b0001, -1, 16'h0, 4'h0);
      run_frame(6, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // Reset during slot 2 with a pending value.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         value_valid = (i == 2);
         value_in    = 16'hDEAD;
         dp_in       = 4'hF;
      end
      value_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("an_midrst", {12'h0, an}, 16'h000F);
      chk("digit_bin_midrst", {12'h0, digit_bin}, 16'h0);
      chk("dp_n_midrst", {15'h0, dp_n}, 16'h1);
      chk("frame_tick_midrst", {15'h0, frame_tick}, 16'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_q.push_back('{val: 16'h0, dp: 4'h0});
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      run_frame(-1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ssd_scan_mux.md
# ssd_scan_mux

Time-multiplexed scanner for a multi-digit common-anode seven-segment display. It accepts a packed hex value from the datapath (for example the adder result) and cycles through the digits one at a time. For each digit it presents that digit's 4-bit nibble to the combinational seven-segment decoder that sits directly downstream, and drives the matching active-low anode and decimal point. New values are committed only at frame boundaries, so a partly updated value is never displayed.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 2..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `value_valid` input 1: one-cycle strobe; captures `value_in` and `dp_in`.
- `value_in` input 4*DIGITS: packed nibbles; bits [3:0] are digit 0 (rightmost).
- `dp_in` input DIGITS: decimal-point request per digit; 1 means lit.
- `digit_bin` output 4: nibble of the active digit, fed to the decoder's `bin` input.
- `an` output DIGITS: active-low anode enables; at most one bit is 0.
- `dp_n` output 1: active-low decimal point for the active digit.
- `frame_tick` output 1: one-cycle pulse when a frame boundary commit happens.

## Operation
- Prescaler `pcnt` counts from 0 to REFRESH_DIV-1 and wraps. `slot_end` is asserted when `pcnt` equals REFRESH_DIV-1.
- Digit index `idx` counts from 0 to DIGITS-1. It advances on `slot_end` and wraps from DIGITS-1 to 0.
- Capture register: on `value_valid`, `shadow_val` is loaded from `value_in`, `shadow_dp` from `dp_in`, and `pending` is set to 1. If several strobes arrive before a boundary, the last one wins.
- Frame boundary is `slot_end` while `idx` is DIGITS-1. At the boundary:
  - If `pending` is set, `disp_val` and `disp_dp` are loaded from the shadow registers and `pending` is cleared.
  - If `value_valid` is asserted in the same cycle, `value_in` and `dp_in` bypass the shadow and commit directly; `pending` ends at 0.
  - `frame_tick` is pulsed at every boundary, whether or not a commit occurred.
- Output registers, updated every cycle from the current `idx` and `disp_*` values:
  - `digit_bin` is the nibble `disp_val[4*idx +: 4]`.
  - `an` is the bitwise inverse of one-hot(`idx`). If the digit is blanked, `an` is all ones instead.
  - `dp_n` is the inverse of `disp_dp[idx]`, and is forced to 1 when the digit is blanked.
- There is no state machine beyond the two counters. Inputs are never back-pressured.

## Timing
- Reset values: `pcnt`=0, `idx`=0, `shadow_*`=0, `disp_*`=0, `pending`=0, `digit_bin`=0, `an`=all ones, `dp_n`=1, `frame_tick`=0.
- First rising edge after `rst_n` deasserts: `an` = ~1 (digit 0 on), `digit_bin`=0.
- Output latency is one cycle from `idx` or `disp_*` to the output pins.
- Each digit is active for exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles.
- A value strobed at cycle t is displayed starting at the first frame boundary at or after t, plus one cycle.
- `frame_tick` is registered and asserts in the cycle after the boundary `slot_end`.
- If `rst_n` is asserted mid-frame, all registers return to their reset values immediately and asynchronously. Any pending value is discarded.

## Configuration
- Macro `SSD_LEADING_ZERO_BLANK_EN`.
- Defined: a digit k ≥ 1 is blanked when it and every more-significant nibble of `disp_val` are 0. Digit 0 is never blanked. For a blanked digit, `an` is all ones and `dp_n` is 1, but `digit_bin` still shows the nibble (0).
- Undefined: no blanking; every digit is shown, including leading zeros.

## Test plan
Conditions: DIGITS=4, REFRESH_DIV=4.
- **Reset:** hold `rst_n`=0 for 3 cycles, release → `an`=4'b1111 during reset; one cycle after release `an`=4'b1110 and `digit_bin`=0. `an` then steps 1101, 1011, 0111 every 4 cycles and wraps to 1110 after 16 cycles.
- **Frame-aligned commit:** strobe `value_in`=16'h1A2F mid-frame with `dp_in`=4'b0100 → the display keeps showing 0000 until the boundary. `frame_tick` pulses once; the next frame shows F, 2, A, 1 on digits 0..3, with `dp_n`=0 only during digit 2.
- **Last-write-wins:** strobe 16'h1111, then 16'h2222 in the same frame → only 2222 is displayed.
- **Boundary collision:** strobe 16'h0BEE on the exact boundary `slot_end` cycle while the shadow holds 16'h5555 → the next frame shows 0BEE, and `pending` is 0 afterwards.
- **Blanking:** `value_in`=16'h0007 → with `SSD_LEADING_ZERO_BLANK_EN` defined, `an` stays 1111 in slots 1–3 and digit 0 shows 7. Without the macro, all four slots are lit. A value of 16'h0000 always shows digit 0 only when blanking is enabled.
- **Reset mid-frame:** pulse `rst_n` low during slot 2 with a pending value → outputs return to reset values, and the pending value is never displayed.
